// File: rtl/arbiter_puf_eval_pkg.sv
// Shared definitions for the PUF evaluators: FSM state encoding and a
// constant clog2 helper usable in parameter and port-width expressions.
package arbiter_puf_eval_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RISE   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_FALL   = 3'd3,
    ST_DONE   = 3'd4
  } puf_state_e;

  localparam int unsigned DEF_N_STAGES      = 64;
  localparam int unsigned DEF_N_EVAL        = 7;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;

  // Smallest r with 2**r >= v (v>=1); elaboration-time use only.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arbiter_puf_eval_switch_stage.sv
// One arbiter-PUF switch stage: a crossed pair of 2:1 muxes.
// sel=0 passes the rails straight through, sel=1 swaps them.
module arbiter_puf_eval_switch_stage (
  input  logic i_top,
  input  logic i_bot,
  input  logic i_sel,
  output logic o_top,
  output logic o_bot
);

  (* keep = "true" *) logic w_top;
  (* keep = "true" *) logic w_bot;

  assign w_top = i_sel ? i_bot : i_top;
  assign w_bot = i_sel ? i_top : i_bot;
  assign o_top = w_top;
  assign o_bot = w_bot;

endmodule

// File: rtl/arbiter_puf_eval.sv
// Arbiter-PUF evaluator: races a launch edge down a switch chain, repeats the
// race N_EVAL times per challenge and majority-votes the arbiter decisions.
module arbiter_puf_eval
  import arbiter_puf_eval_pkg::*;
#(
  parameter int unsigned N_STAGES      = DEF_N_STAGES,
  parameter int unsigned N_EVAL        = DEF_N_EVAL,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter bit          USE_EXT_ARB   = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [N_STAGES-1:0]               challenge,
  input  logic                              ext_arb_i,
  output logic                              busy,
  output logic                              done,
  output logic                              response,
  output logic [clog2_f(N_EVAL+1)-1:0]      confidence,
  output logic                              stable,
  output logic                              launch_o
);

  localparam int unsigned CW = clog2_f(N_EVAL + 1);
  localparam int unsigned SW = clog2_f(SETTLE_CYCLES);

  if ((N_EVAL % 2) == 0 || N_EVAL < 1) begin : g_bad_eval
    $error("arbiter_puf_eval: N_EVAL must be odd and >= 1");
  end
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("arbiter_puf_eval: SETTLE_CYCLES must be >= 3");
  end
  if (N_STAGES < 1) begin : g_bad_stages
    $error("arbiter_puf_eval: N_STAGES must be >= 1");
  end

  puf_state_e          r_state;
  logic [N_STAGES-1:0] r_challenge;
  logic [CW-1:0]       r_ones_cnt;
  logic [CW-1:0]       r_eval_cnt;
  logic [SW-1:0]       r_settle;
  logic                r_launch;
  logic                r_busy;
  logic                r_done;
  logic                r_response;
  logic [CW-1:0]       r_confidence;
  logic                r_stable;
  logic                r_arb;
  logic                r_sync1;
  logic                r_sync2;

  logic w_top [N_STAGES+1];
  logic w_bot [N_STAGES+1];
  logic w_arb_clr;
  logic w_arb_bit;

  // Race chain: both rails start from the same launch level.
  assign w_top[0] = r_launch;
  assign w_bot[0] = r_launch;

  for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
    arbiter_puf_eval_switch_stage u_stage (
      .i_top (w_top[g]),
      .i_bot (w_bot[g]),
      .i_sel (r_challenge[g]),
      .o_top (w_top[g+1]),
      .o_bot (w_bot[g+1])
    );
  end

  // Arbiter: top rail sampled by the bottom rail edge, held clear while launch is low.
  assign w_arb_clr = ~r_launch;

  always_ff @(posedge w_bot[N_STAGES] or posedge w_arb_clr) begin
    if (w_arb_clr) r_arb <= 1'b0;
    else           r_arb <= w_top[N_STAGES];
  end

  assign w_arb_bit = USE_EXT_ARB ? ext_arb_i : r_arb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= w_arb_bit;
      r_sync2 <= r_sync1;
    end
  end

  // Evaluation FSM with counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_challenge  <= '0;
      r_ones_cnt   <= '0;
      r_eval_cnt   <= '0;
      r_settle     <= '0;
      r_launch     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_response   <= 1'b0;
      r_confidence <= '0;
      r_stable     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_challenge <= challenge;
            r_ones_cnt  <= '0;
            r_eval_cnt  <= '0;
            r_settle    <= '0;
            r_launch    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_RISE;
          end
        end
        ST_RISE: begin
          if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
            r_settle <= '0;
            r_state  <= ST_SAMPLE;
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end
        ST_SAMPLE: begin
          r_ones_cnt <= r_ones_cnt + CW'(r_sync2);
          r_eval_cnt <= r_eval_cnt + CW'(1);
          r_launch   <= 1'b0;
          r_state    <= ST_FALL;
        end
        ST_FALL: begin
          if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
            r_settle <= '0;
            if (r_eval_cnt == CW'(N_EVAL)) begin
              r_done       <= 1'b1;
              r_response   <= (r_ones_cnt > CW'(N_EVAL / 2));
              r_confidence <= r_ones_cnt;
              r_stable     <= (r_ones_cnt == '0) || (r_ones_cnt == CW'(N_EVAL));
              r_state      <= ST_DONE;
            end else begin
              r_launch <= 1'b1;
              r_state  <= ST_RISE;
            end
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_launch <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign response   = r_response;
  assign confidence = r_confidence;
  assign stable     = r_stable;
  assign launch_o   = r_launch;

endmodule
